decoder_n_seq: RTL and testbench

DECODER_N_SEQ -- requirements
Module: decoder_n_seq

---
 rtl/decoder_pkg.sv | 14 +
 rtl/dwell_timer.sv | 39 +++
 rtl/decoder_n_seq.sv | 92 +++++++++
 tb/tb_decoder_n_seq.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/decoder_pkg.sv
// Shared constants for the one-hot decoder/sequencer: command mode encoding
// and the controller state encoding.
package decoder_pkg;

  localparam logic MODE_DIRECT = 1'b0;
  localparam logic MODE_SCAN   = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DIRECT = 2'd1,
    ST_SCAN   = 2'd2
  } state_e;

endpackage

// File: rtl/dwell_timer.sv
// Dwell counter for SCAN mode: counts 0..DWELL-1 while run is high and flags
// the terminal count; clr returns it to zero.
module dwell_timer #(
  parameter int DWELL = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic run,
  output logic tc
);

  localparam int CW = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [CW-1:0] LAST = CW'(DWELL - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  // tc is a pure function of the count so the controller can gate it with run
  // without forming a combinational loop through this block.
  assign tc = (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (run) begin
      cnt_d = tc ? '0 : cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/decoder_n_seq.sv
// Registered one-hot decoder with a DIRECT (hold one line) mode and a SCAN
// mode that steps through all lines, dwelling DWELL cycles on each.
module decoder_n_seq
  import decoder_pkg::*;
#(
  parameter int SEL_W = 3,
  parameter int OUT_W = 2**SEL_W,
  parameter int DWELL = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [SEL_W-1:0] sel,
  input  logic             mode,
  output logic [OUT_W-1:0] out,
  output logic             out_valid,
  output logic [SEL_W-1:0] idx,
  output logic             wrap
);

  state_e           state_q, state_d;
  logic [SEL_W-1:0] idx_q, idx_d;
  logic [OUT_W-1:0] out_q, out_d;
  logic             vld_q, vld_d;
  logic             wrap_q, wrap_d;
  logic             accept, tc, tmr_clr, tmr_run;

  assign in_ready = en;
  assign accept   = in_valid && en;

  dwell_timer #(
    .DWELL(DWELL)
  ) u_timer (
    .clk(clk),
    .rst(rst),
    .clr(tmr_clr),
    .run(tmr_run),
    .tc (tc)
  );

  // Priority: en low, then a new command, then the scan advance.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    vld_d   = vld_q;
    wrap_d  = 1'b0;
    tmr_clr = 1'b0;
    tmr_run = 1'b0;
    if (!en) begin
      state_d = ST_IDLE;
      idx_d   = '0;
      vld_d   = 1'b0;
      tmr_clr = 1'b1;
    end else if (accept) begin
      state_d = (mode == MODE_SCAN) ? ST_SCAN : ST_DIRECT;
      idx_d   = sel;
      vld_d   = 1'b1;
      tmr_clr = 1'b1;
    end else if (state_q == ST_SCAN) begin
      tmr_run = 1'b1;
      if (tc) begin
        idx_d  = idx_q + SEL_W'(1);
        wrap_d = (idx_q == SEL_W'(OUT_W - 1));
      end
    end
    out_d = vld_d ? (OUT_W'(1) << idx_d) : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      out_q   <= '0;
      vld_q   <= 1'b0;
      wrap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      out_q   <= out_d;
      vld_q   <= vld_d;
      wrap_q  <= wrap_d;
    end
  end

  assign out       = out_q;
  assign out_valid = vld_q;
  assign idx       = idx_q;
  assign wrap      = wrap_q;

endmodule

// File: tb/tb_decoder_n_seq.sv
// Scoreboard bench for decoder_n_seq: a DWELL=4 instance and a DWELL=1
// instance share stimulus; expected cycles are queued then checked per edge.
module tb_decoder_n_seq;

  typedef struct packed {
    logic [7:0] o;
    logic [2:0] i;
    logic       v;
    logic       w;
    logic       r;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst, en, in_valid, mode;
  logic [2:0] sel;

  logic       rdy, dvld, dwrap;
  logic [7:0] dout;
  logic [2:0] didx;
  logic       rdy1, dvld1, dwrap1;
  logic [7:0] dout1;
  logic [2:0] didx1;

  exp_t obs, obs1, e;
  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;

  assign obs  = {dout, didx, dvld, dwrap, rdy};
  assign obs1 = {dout1, didx1, dvld1, dwrap1, rdy1};

  always #5 clk = ~clk;

  decoder_n_seq #(.SEL_W(3), .DWELL(4)) dut (
    .clk(clk), .rst(rst), .en(en), .in_valid(in_valid), .in_ready(rdy),
    .sel(sel), .mode(mode), .out(dout), .out_valid(dvld), .idx(didx), .wrap(dwrap)
  );

  decoder_n_seq #(.SEL_W(3), .DWELL(1)) dut1 (
    .clk(clk), .rst(rst), .en(en), .in_valid(in_valid), .in_ready(rdy1),
    .sel(sel), .mode(mode), .out(dout1), .out_valid(dvld1), .idx(didx1), .wrap(dwrap1)
  );

  function automatic exp_t mk(int i, bit v, bit w, bit r);
    exp_t t;
    t.o = v ? (8'd1 << i) : 8'd0;
    t.i = v ? 3'(i) : 3'd0;
    t.v = v;
    t.w = w;
    t.r = r;
    return t;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cmd(input logic m, input logic [2:0] s);
    in_valid = 1'b1;
    mode     = m;
    sel      = s;
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b0; in_valid = 1'b0; mode = 1'b0; sel = 3'd0;
    exp_q.push_back(mk(0, 0, 0, 0));
    exp_q.push_back(mk(0, 0, 0, 1));
    exp_q.push_back(mk(0, 0, 0, 1));
    for (int k = 0; k < 3; k++) begin
      tick();
      e = exp_q.pop_front();
      checks += 2;
      if (obs !== e) begin
        errors++;
        $display("FAIL reset k=%0d dut got out=%b idx=%0d v=%b w=%b r=%b want out=%b idx=%0d v=%b w=%b r=%b",
                 k, obs.o, obs.i, obs.v, obs.w, obs.r, e.o, e.i, e.v, e.w, e.r);
      end
      if (obs1 !== e) begin
        errors++;
        $display("FAIL reset k=%0d dut1 got out=%b idx=%0d v=%b w=%b r=%b want out=%b idx=%0d v=%b w=%b r=%b",
                 k, obs1.o, obs1.i, obs1.v, obs1.w, obs1.r, e.o, e.i, e.v, e.w, e.r);
      end
      if (k == 0) begin
        en = 1'b1;
        cmd(1'b1, 3'd3);
      end else begin
        rst = 1'b0;
        in_valid = 1'b0;
      end
    end
  endtask

  task automatic test_direct();
    logic [2:0] svals [3] = '{3'd5, 3'd0, 3'd7};
    for (int n = 0; n < 3; n++) begin
      for (int k = 0; k < 4; k++) exp_q.push_back(mk(svals[n], 1, 0, 1));
      cmd(1'b0, svals[n]);
      for (int k = 0; k < 4; k++) begin
        tick();
        in_valid = 1'b0;
        e = exp_q.pop_front();
        checks++;
        if (obs !== e) begin
          errors++;
          $display("FAIL direct sel=%0d k=%0d got out=%b idx=%0d v=%b w=%b r=%b want out=%b idx=%0d v=%b w=%b r=%b",
                   svals[n], k, obs.o, obs.i, obs.v, obs.w, obs.r, e.o, e.i, e.v, e.w, e.r);
        end
        if (n == 0 && k == 3) begin
          checks++;
          if (dout !== 8'b0010_0000) begin
            errors++;
            $display("FAIL direct_sel5_hold got out=%b want 00100000", dout);
          end
        end
      end
    end
  endtask

  task automatic test_scan();
    for (int k = 0; k < 18; k++) begin
      int pos = k / 4;
      int ix  = (6 + pos) % 8;
      exp_q.push_back(mk(ix, 1, (k % 4 == 0) && (pos > 0) && (ix == 0), 1));
    end
    cmd(1'b1, 3'd6);
    for (int k = 0; k < 18; k++) begin
      tick();
      in_valid = 1'b0;
      e = exp_q.pop_front();
      checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL scan k=%0d got out=%b idx=%0d v=%b w=%b r=%b want out=%b idx=%0d v=%b w=%b r=%b",
                 k, obs.o, obs.i, obs.v, obs.w, obs.r, e.o, e.i, e.v, e.w, e.r);
      end
    end
  endtask

  task automatic test_dwell1();
    for (int k = 0; k < 24; k++) exp_q.push_back(mk(k % 8, 1, (k > 0) && (k % 8 == 0), 1));
    cmd(1'b1, 3'd0);
    for (int k = 0; k < 24; k++) begin
      tick();
      in_valid = 1'b0;
      e = exp_q.pop_front();
      checks++;
      if (obs1 !== e) begin
        errors++;
        $display("FAIL dwell1 k=%0d got out=%b idx=%0d v=%b w=%b r=%b want out=%b idx=%0d v=%b w=%b r=%b",
                 k, obs1.o, obs1.i, obs1.v, obs1.w, obs1.r, e.o, e.i, e.v, e.w, e.r);
      end
    end
  endtask

  task automatic test_preempt_tc();
    for (int k = 0; k < 4; k++) exp_q.push_back(mk(7, 1, 0, 1));
    for (int k = 0; k < 10; k++) exp_q.push_back(mk(2, 1, 0, 1));
    cmd(1'b1, 3'd7);
    for (int k = 0; k < 14; k++) begin
      tick();
      in_valid = 1'b0;
      e = exp_q.pop_front();
      checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL preempt k=%0d got out=%b idx=%0d v=%b w=%b r=%b want out=%b idx=%0d v=%b w=%b r=%b",
                 k, obs.o, obs.i, obs.v, obs.w, obs.r, e.o, e.i, e.v, e.w, e.r);
      end
      if (k == 3) cmd(1'b0, 3'd2);
      if (k == 4) begin
        checks++;
        if (dout !== 8'b0000_0100) begin
          errors++;
          $display("FAIL preempt_out got out=%b want 00000100", dout);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    for (int s = 0; s < 8; s++) exp_q.push_back(mk(s, 1, 0, 1));
    for (int k = 0; k < 4; k++) exp_q.push_back(mk(4, 1, 0, 1));
    for (int k = 0; k < 4; k++) exp_q.push_back(mk(3, 1, 0, 1));
    exp_q.push_back(mk(4, 1, 0, 1));
    for (int k = 0; k < 17; k++) begin
      if (k < 8) cmd(1'b0, 3'(k));
      else if (k == 8) cmd(1'b1, 3'd4);
      else if (k == 12) cmd(1'b1, 3'd3);
      tick();
      in_valid = 1'b0;
      e = exp_q.pop_front();
      checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL b2b k=%0d got out=%b idx=%0d v=%b w=%b r=%b want out=%b idx=%0d v=%b w=%b r=%b",
                 k, obs.o, obs.i, obs.v, obs.w, obs.r, e.o, e.i, e.v, e.w, e.r);
      end
    end
  endtask

  task automatic test_en_drop();
    exp_q.push_back(mk(2, 1, 0, 1));
    exp_q.push_back(mk(2, 1, 0, 1));
    exp_q.push_back(mk(0, 0, 0, 0));
    exp_q.push_back(mk(0, 0, 0, 0));
    for (int k = 0; k < 5; k++) exp_q.push_back(mk(0, 0, 0, 1));
    exp_q.push_back(mk(7, 1, 0, 1));
    cmd(1'b1, 3'd2);
    for (int k = 0; k < 10; k++) begin
      tick();
      in_valid = 1'b0;
      if (k == 1) begin
        en = 1'b0;
        cmd(1'b1, 3'd5);
      end
      if (k == 3) en = 1'b1;
      if (k == 8) cmd(1'b0, 3'd7);
      e = exp_q.pop_front();
      checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL en_drop k=%0d got out=%b idx=%0d v=%b w=%b r=%b want out=%b idx=%0d v=%b w=%b r=%b",
                 k, obs.o, obs.i, obs.v, obs.w, obs.r, e.o, e.i, e.v, e.w, e.r);
      end
      if (k == 1) in_valid = 1'b1;
    end
    in_valid = 1'b0;
  endtask

  task automatic test_rst_mid();
    for (int k = 0; k < 4; k++) exp_q.push_back(mk(7, 1, 0, 1));
    for (int k = 0; k < 4; k++) exp_q.push_back(mk(0, 0, 0, 1));
    cmd(1'b1, 3'd7);
    for (int k = 0; k < 8; k++) begin
      tick();
      in_valid = 1'b0;
      rst = 1'b0;
      e = exp_q.pop_front();
      checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL rst_mid k=%0d got out=%b idx=%0d v=%b w=%b r=%b want out=%b idx=%0d v=%b w=%b r=%b",
                 k, obs.o, obs.i, obs.v, obs.w, obs.r, e.o, e.i, e.v, e.w, e.r);
      end
      if (k == 3) begin
        rst = 1'b1;
        cmd(1'b0, 3'd1);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_direct();
    test_scan();
    test_dwell1();
    test_preempt_tc();
    test_back_to_back();
    test_en_drop();
    test_rst_mid();
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_leftover got %0d entries want 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
